// File: rtl/isp_frame_sequencer.sv
// -----------------------------------------------------------------------------
// isp_frame_sequencer
//
// Sequences one Bayer frame into the demosaic stage. After a frame request it
// issues a one-cycle `start`, pulls pixels from a ready/valid source with a
// fixed idle gap between them, and tags each issued pixel with `end_col` /
// `end_pic` from internal counters. It then waits for the frame's last pixel
// to leave the pipeline tail before pulsing `done`.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : a 16-bit drain watchdog pulses `err` and returns to IDLE after
//               TIMEOUT cycles in DRAIN with no tail event.
//   undefined : `err` is tied 0 and DRAIN waits indefinitely.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   frame_req             start one frame (sampled only in IDLE)
//   abort                 synchronous abort, highest priority, back to IDLE
//   src_valid/src_data    pixel source
//   src_ready             combinational, high only in FEED
//   start                 one-cycle frame start pulse (registered)
//   valid/data_in         registered pixel strobe and pixel to demosaic
//   end_col/end_pic       last-of-strip / last-of-frame, qualify `valid`
//   tail_valid/_last_pic  pipeline tail status, observed only in DRAIN
//   busy                  registered, high whenever the state is not IDLE
//   done                  one-cycle frame-complete pulse
//   err                   one-cycle drain-timeout pulse
// -----------------------------------------------------------------------------
module isp_frame_sequencer #(
  parameter int COLOR_DEPTH = 8,
  parameter int COL_LEN     = 64,
  parameter int PIC_LEN     = 128,
  parameter int GAP         = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_req,
  input  logic                   abort,
  input  logic                   src_valid,
  input  logic [COLOR_DEPTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   start,
  output logic                   valid,
  output logic [COLOR_DEPTH-1:0] data_in,
  output logic                   end_col,
  output logic                   end_pic,
  input  logic                   tail_valid,
  input  logic                   tail_last_pic,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int CW = (COL_LEN > 1) ? $clog2(COL_LEN) : 1;
  localparam int PW = (PIC_LEN > 1) ? $clog2(PIC_LEN) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(COL_LEN - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIC_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);

  // Reject configurations the counters cannot represent.
  if ((COL_LEN < 1) || (PIC_LEN < COL_LEN) || ((PIC_LEN % COL_LEN) != 0) ||
      (GAP < 0) || (TIMEOUT < 1) || (TIMEOUT > 65536)) begin : g_bad_cfg
    $error("isp_frame_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_FEED  = 3'd2,
    S_GAPW  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          col_cnt_q, col_cnt_d;
  logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [COLOR_DEPTH-1:0] data_in_q, data_in_d;
  logic                   valid_q, valid_d;
  logic                   start_q, start_d;
  logic                   end_col_q, end_col_d;
  logic                   end_pic_q, end_pic_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hs_s;
  logic                   last_pix_s;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]            to_cnt_q, to_cnt_d;
  logic                   err_q, err_d;
`endif

  // Ready is decoded straight from state so the source sees it in the FEED cycle.
  assign src_ready  = (state_q == S_FEED);
  assign hs_s       = src_valid && src_ready;
  assign last_pix_s = (pix_cnt_q == PIX_LAST);

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    pix_cnt_d = pix_cnt_q;
    gap_cnt_d = gap_cnt_q;
    data_in_d = data_in_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    end_col_d = 1'b0;
    end_pic_d = 1'b0;
    done_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    err_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (frame_req) begin
          state_d = S_START;
          start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        col_cnt_d = '0;
        pix_cnt_d = '0;
        if (GAP == 0) begin
          state_d = S_FEED;
        end else begin
          state_d   = S_GAPW;
          gap_cnt_d = GAP_LOAD;
        end
      end

      S_FEED: begin
        if (hs_s) begin
          data_in_d = src_data;
          valid_d   = 1'b1;
          end_col_d = (col_cnt_q == COL_LAST);
          end_pic_d = last_pix_s;
          col_cnt_d = (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + CW'(1);
          pix_cnt_d = last_pix_s ? '0 : pix_cnt_q + PW'(1);
          if (last_pix_s) begin
            state_d = S_DRAIN;
`ifdef SEQ_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end else if (GAP == 0) begin
            state_d = S_FEED;
          end else begin
            state_d   = S_GAPW;
            gap_cnt_d = GAP_LOAD;
          end
        end else begin
          state_d = S_FEED;
        end
      end

      S_GAPW: begin
        // The count reaching 1 ends the gap, so exactly GAP cycles are spent here.
        if (gap_cnt_q <= GW'(1)) begin
          state_d = S_FEED;
        end else begin
          gap_cnt_d = gap_cnt_q - GW'(1);
        end
      end

      S_DRAIN: begin
        if (tail_valid && tail_last_pic) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
`ifdef SEQ_TIMEOUT_EN
          if (to_cnt_q == TO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
`else
          state_d = S_DRAIN;
`endif
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition and suppresses all strobes.
    if (abort) begin
      state_d   = S_IDLE;
      col_cnt_d = '0;
      pix_cnt_d = '0;
      gap_cnt_d = '0;
      valid_d   = 1'b0;
      start_d   = 1'b0;
      end_col_d = 1'b0;
      end_pic_d = 1'b0;
      done_d    = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_d  = '0;
      err_d     = 1'b0;
`endif
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_cnt_q <= '0;
      pix_cnt_q <= '0;
      gap_cnt_q <= '0;
      data_in_q <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      end_col_q <= 1'b0;
      end_pic_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      pix_cnt_q <= pix_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      data_in_q <= data_in_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      end_col_q <= end_col_d;
      end_pic_q <= end_pic_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  assign start   = start_q;
  assign valid   = valid_q;
  assign data_in = data_in_q;
  assign end_col = end_col_q;
  assign end_pic = end_pic_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef SEQ_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_isp_frame_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for isp_frame_sequencer with default parameters
// (COLOR_DEPTH=8, COL_LEN=64, PIC_LEN=128, GAP=2). Inputs are driven and
// outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_isp_frame_sequencer;

  localparam int COL_LEN = 64;
  localparam int PIC_LEN = 128;
  localparam int PERIOD  = 3;   // GAP + 1

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_req;
  logic       abort;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       start;
  logic       valid;
  logic [7:0] data_in;
  logic       end_col;
  logic       end_pic;
  logic       tail_valid;
  logic       tail_last_pic;
  logic       busy;
  logic       done;
  logic       err;

  int errors = 0;
  int checks = 0;

  isp_frame_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_req     (frame_req),
    .abort         (abort),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .start         (start),
    .valid         (valid),
    .data_in       (data_in),
    .end_col       (end_col),
    .end_pic       (end_pic),
    .tail_valid    (tail_valid),
    .tail_last_pic (tail_last_pic),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a frame from IDLE and walk through START and the initial gap.
  task automatic begin_frame();
    frame_req = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'd0;
    tick();
    chk("start_pulse", start, 1'b1);
    chk("busy_at_start", busy, 1'b1);
    frame_req = 1'b0;
    tick();
    chk("start_one_cycle", start, 1'b0);
    chk("gap1_not_ready", src_ready, 1'b0);
    tick();
    chk("gap2_not_ready", src_ready, 1'b0);
    tick();
    chk("feed_ready", src_ready, 1'b1);
  endtask

  // Feed pixels valued by index until stop_at pixels have been seen.
  task automatic run_frame(input int stop_at, input int stall_at, input int tail_at,
                           input logic hold_req);
    int idx = 0;
    int cyc = 0;
    int last_cyc = -1;
    int stall_cnt = 0;
    frame_req = hold_req;
    while ((idx < stop_at) && (cyc < 3000)) begin
      tick();
      cyc++;
      if (stall_cnt > 0) begin
        chk("stall_no_valid", valid, 1'b0);
        stall_cnt--;
        if (stall_cnt == 0) src_valid = 1'b1;
      end else if (valid) begin
        chk("data_in", data_in, idx);
        chk("end_col", end_col, ((idx % COL_LEN) == COL_LEN - 1));
        chk("end_pic", end_pic, (idx == PIC_LEN - 1));
        chk("no_done_in_feed", done, 1'b0);
        chk("no_restart", start, 1'b0);
        if ((last_cyc >= 0) && (idx != stall_at)) chk("spacing", cyc - last_cyc, PERIOD);
        last_cyc = cyc;
        idx++;
        src_data = 8'(idx);
        if (idx == stall_at) begin
          src_valid = 1'b0;
          stall_cnt = 5;
        end
        if (idx == tail_at) begin
          tail_valid    = 1'b1;
          tail_last_pic = 1'b1;
        end else if (idx == tail_at + 1) begin
          tail_valid    = 1'b0;
          tail_last_pic = 1'b0;
        end
      end
    end
    frame_req = 1'b0;
    chk("pixel_count", idx, stop_at);
  endtask

  // Wait in DRAIN, ignore a non-last tail beat, then complete on the last one.
  task automatic finish_frame();
    tail_valid    = 1'b1;
    tail_last_pic = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_no_valid", valid, 1'b0);
      chk("drain_no_done", done, 1'b0);
      chk("drain_busy", busy, 1'b1);
      chk("drain_not_ready", src_ready, 1'b0);
    end
    tail_last_pic = 1'b1;
    tick();
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b1);
    tail_valid    = 1'b0;
    tail_last_pic = 1'b0;
    tick();
    chk("done_one_cycle", done, 1'b0);
    chk("idle_after_done", busy, 1'b0);
    chk("no_err", err, 1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    frame_req     = 1'b1;
    abort         = 1'b0;
    src_valid     = 1'b0;
    src_data      = 8'd0;
    tail_valid    = 1'b0;
    tail_last_pic = 1'b0;

    // Reset held with frame_req asserted: every output stays low.
    tick();
    tick();
    chk("rst_start", start, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_data", data_in, 8'd0);
    chk("rst_end_col", end_col, 1'b0);
    chk("rst_end_pic", end_pic, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", src_ready, 1'b0);

    // Release with frame_req still high: start and busy one cycle later.
    rst_n = 1'b1;
    begin_frame();

    // Frame 1: clean always-valid frame.
    run_frame(PIC_LEN, -1, -1, 1'b0);
    finish_frame();

    // Frame 2: source stall at pixel 40, tail event during FEED, frame_req held.
    begin_frame();
    run_frame(PIC_LEN, 40, 10, 1'b1);
    finish_frame();

    // Frame 3: abort at pixel 70.
    begin_frame();
    run_frame(70, -1, -1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_end_col", end_col, 1'b0);
    tick();
    chk("abort_stays_idle", busy, 1'b0);

    // Frame 4: restart after abort, counters start from pixel 0 again.
    begin_frame();
    run_frame(PIC_LEN, -1, -1, 1'b0);
    finish_frame();

    // Reset mid-frame clears outputs without waiting for a clock edge.
    begin_frame();
    run_frame(6, -1, -1, 1'b0);
    chk("pre_reset_valid", valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_data", data_in, 8'd0);
    chk("async_rst_end_pic", end_pic, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
